// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between the EX-stage controller
//               (master) and the iterative RV32M multiply/divide unit (slave).
//               start  - request, sampled only while the unit is idle
//               flush  - abort an in-flight operation / block a request
//               select - operation code (M-extension codes, see muldiv_unit)
//               data1  - rs1 operand (multiplicand / dividend)
//               data2  - rs2 operand (multiplier / divisor)
//               result - registered result, holds the last completed value
//               busy   - high while an operation is in flight
//               valid  - one-cycle pulse, result is valid in that cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if;
   logic        start;
   logic        flush;
   logic [4:0]  select;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [31:0] result;
   logic        busy;
   logic        valid;

   modport master (
      output start, flush, select, data1, data2,
      input  result, busy, valid
   );

   modport slave (
      input  start, flush, select, data1, data2,
      output result, busy, valid
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M execution unit. A request accepted in IDLE
//               runs 32 iterations of shift-add multiply or restoring divide
//               on operand magnitudes; the sign is applied at the final
//               iteration, where the registered result and a one-cycle valid
//               pulse are produced. Latency is fixed at 32 cycles.
// Ports       : clk - rising-edge clock
//               rst - asynchronous active-high reset, clears all state
//               bus - muldiv_unit_if slave modport (start, flush, select,
//                     data1, data2 in; result, busy, valid out)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit (
   input  logic          clk,
   input  logic          rst,
   muldiv_unit_if.slave  bus
);

   // Operation codes shared with the single-cycle ALU decode.
   localparam logic [4:0] c_sel_mul    = 5'b01000;
   localparam logic [4:0] c_sel_mulh   = 5'b01001;
   localparam logic [4:0] c_sel_mulhsu = 5'b01010;
   localparam logic [4:0] c_sel_mulhu  = 5'b01011;
   localparam logic [4:0] c_sel_div    = 5'b01100;
   localparam logic [4:0] c_sel_divu   = 5'b01101;
   localparam logic [4:0] c_sel_rem    = 5'b01110;
   localparam logic [4:0] c_sel_remu   = 5'b01111;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_CALC = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [4:0]  r_sel;
   logic [31:0] r_a;        // magnitude of data1
   logic [31:0] r_b;        // magnitude of data2
   logic [31:0] r_d1;       // original data1, returned by REM/REMU x/0
   logic        r_neg;      // final result must be negated
   logic        r_dz;       // divisor was zero
   logic        r_ovf;      // signed 0x80000000 / -1
   logic [4:0]  r_cnt;
   logic [63:0] r_acc;      // product, or quotient in [31:0] when dividing
   logic [31:0] r_rem;      // partial remainder
   logic [31:0] r_result;
   logic        r_valid;

   // ---------------------------------------------------------------------
   // Request decode (operates on the live inputs, used only at accept)
   // ---------------------------------------------------------------------
   logic        w_is_m;
   logic        w_s1_signed;
   logic        w_s2_signed;
   logic        w_neg1;
   logic        w_neg2;
   logic [31:0] w_mag1;
   logic [31:0] w_mag2;
   logic        w_res_neg;
   logic        w_ovf_in;
   logic        w_accept;
   logic        w_calc;

   assign w_is_m      = bus.select inside {c_sel_mul, c_sel_mulh, c_sel_mulhsu, c_sel_mulhu,
                                           c_sel_div, c_sel_divu, c_sel_rem, c_sel_remu};
   assign w_s1_signed = bus.select inside {c_sel_mulh, c_sel_mulhsu, c_sel_div, c_sel_rem};
   assign w_s2_signed = bus.select inside {c_sel_mulh, c_sel_div, c_sel_rem};
   assign w_neg1      = w_s1_signed & bus.data1[31];
   assign w_neg2      = w_s2_signed & bus.data2[31];
   // 0x80000000 negates to itself, which reads correctly as unsigned 2^31.
   assign w_mag1      = w_neg1 ? (32'd0 - bus.data1) : bus.data1;
   assign w_mag2      = w_neg2 ? (32'd0 - bus.data2) : bus.data2;
   // Remainder takes the dividend sign; everything else the XOR of signs.
   assign w_res_neg   = (bus.select inside {c_sel_rem, c_sel_remu}) ? w_neg1 : (w_neg1 ^ w_neg2);
   assign w_ovf_in    = (bus.select inside {c_sel_div, c_sel_rem}) &&
                        (bus.data1 == 32'h8000_0000) && (bus.data2 == 32'hFFFF_FFFF);

   assign w_accept    = (r_state == S_IDLE) && bus.start && !bus.flush && w_is_m;
   assign w_calc      = (r_state == S_CALC) && !bus.flush;

   // ---------------------------------------------------------------------
   // One iteration, MSB first: r_cnt selects the operand bit consumed.
   // ---------------------------------------------------------------------
   logic        w_is_div;
   logic [63:0] w_acc_mul;
   logic [32:0] w_shift;     // 33-bit shifted partial remainder
   logic        w_ge;
   logic [31:0] w_rem_div;
   logic [31:0] w_quo_div;
   logic [63:0] w_acc_nxt;

   assign w_is_div  = r_sel inside {c_sel_div, c_sel_divu, c_sel_rem, c_sel_remu};
   assign w_acc_mul = (r_acc << 1) + (r_b[r_cnt] ? {32'd0, r_a} : 64'd0);
   assign w_shift   = {r_rem, r_a[r_cnt]};
   assign w_ge      = (w_shift >= {1'b0, r_b});
   // When w_ge holds the difference is below r_b, so 32 bits are exact.
   assign w_rem_div = w_ge ? (w_shift[31:0] - r_b) : w_shift[31:0];
   assign w_quo_div = {r_acc[30:0], w_ge};
   assign w_acc_nxt = w_is_div ? {32'd0, w_quo_div} : w_acc_mul;

   // ---------------------------------------------------------------------
   // Final result, applied on the iteration with r_cnt == 0
   // ---------------------------------------------------------------------
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic [31:0] w_result;

   assign w_prod = r_neg ? (64'd0 - w_acc_mul) : w_acc_mul;
   assign w_quo  = r_neg ? (32'd0 - w_quo_div) : w_quo_div;
   assign w_rem  = r_neg ? (32'd0 - w_rem_div) : w_rem_div;

   always_comb begin
      w_result = 32'd0;
      case (r_sel)
         c_sel_mul:                            w_result = w_prod[31:0];
         c_sel_mulh, c_sel_mulhsu, c_sel_mulhu: w_result = w_prod[63:32];
         c_sel_div, c_sel_divu: begin
            if (r_dz)       w_result = 32'hFFFF_FFFF;
            else if (r_ovf) w_result = 32'h8000_0000;
            else            w_result = w_quo;
         end
         c_sel_rem, c_sel_remu: begin
            if (r_dz)       w_result = r_d1;
            else if (r_ovf) w_result = 32'd0;
            else            w_result = w_rem;
         end
         default:                              w_result = 32'd0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_CALC;
         S_CALC: if (bus.flush || (r_cnt == 5'd0)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel    <= 5'd0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_d1     <= 32'd0;
         r_neg    <= 1'b0;
         r_dz     <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= 5'd0;
         r_acc    <= 64'd0;
         r_rem    <= 32'd0;
         r_result <= 32'd0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            r_sel <= bus.select;
            r_a   <= w_mag1;
            r_b   <= w_mag2;
            r_d1  <= bus.data1;
            r_neg <= w_res_neg;
            r_dz  <= (bus.data2 == 32'd0);
            r_ovf <= w_ovf_in;
            r_cnt <= 5'd31;
            r_acc <= 64'd0;
            r_rem <= 32'd0;
         end else if (w_calc) begin
            r_acc <= w_acc_nxt;
            r_rem <= w_rem_div;
            if (r_cnt == 5'd0) begin
               r_result <= w_result;
               r_valid  <= 1'b1;
            end else begin
               r_cnt <= r_cnt - 5'd1;
            end
         end
      end
   end

   assign bus.result = r_result;
   assign bus.valid  = r_valid;
   assign bus.busy   = (r_state == S_CALC);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit: arithmetic
//               results, fixed latency, boundary overrides, flush, back-to-
//               back issue, asynchronous reset and ignored requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

   localparam logic [4:0] c_sel_add    = 5'b00000;
   localparam logic [4:0] c_sel_mul    = 5'b01000;
   localparam logic [4:0] c_sel_mulh   = 5'b01001;
   localparam logic [4:0] c_sel_mulhsu = 5'b01010;
   localparam logic [4:0] c_sel_mulhu  = 5'b01011;
   localparam logic [4:0] c_sel_div    = 5'b01100;
   localparam logic [4:0] c_sel_divu   = 5'b01101;
   localparam logic [4:0] c_sel_rem    = 5'b01110;
   localparam logic [4:0] c_sel_remu   = 5'b01111;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   muldiv_unit_if bus ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Present a request before the next edge (edge 0) and drop START after it.
   // Operands are scrambled afterwards so only the latched copies matter.
   task automatic issue(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.select = s;
      bus.data1  = a;
      bus.data2  = b;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.data1  = 32'hDEAD_BEEF;
      bus.data2  = 32'h1234_5678;
   endtask

   // Edges counted from edge 0 until VALID is seen; lat=0 if it never comes.
   task automatic wait_valid(output logic [31:0] res, output int lat);
      lat = 0;
      res = 32'd0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (bus.valid) begin
            lat = n;
            res = bus.result;
            break;
         end
      end
   endtask

   // Counts VALID pulses over a window of cycles.
   task automatic count_valid(input int cycles, output int seen);
      seen = 0;
      for (int n = 0; n < cycles; n++) begin
         @(posedge clk);
         #1;
         if (bus.valid) seen++;
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.select = c_sel_add;
      bus.data1  = 32'd0;
      bus.data2  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.result !== 32'd0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL reset: result=%h busy=%b valid=%b, required 0/0/0",
                  bus.result, bus.busy, bus.valid);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ignored();
      int seen;
      issue(c_sel_add, 32'd3, 32'd4);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ignored_busy: busy=%b, required 0", bus.busy);
      end
      count_valid(40, seen);
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL ignored_valid: %0d valid pulses, required 0", seen);
      end
      // FLUSH in IDLE blocks an otherwise valid request.
      @(negedge clk);
      bus.select = c_sel_mul;
      bus.data1  = 32'd7;
      bus.data2  = 32'd6;
      bus.flush  = 1'b1;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_flush_blocks: busy=%b, required 0", bus.busy);
      end
   endtask

   task automatic test_mul();
      logic [31:0] res;
      int          lat;
      issue(c_sel_mul, 32'd7, 32'd6);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mul_busy_rise: busy=%b, required 1", bus.busy);
      end
      wait_valid(res, lat);
      checks++;
      if (res !== 32'd42 || lat !== 32) begin
         errors++;
         $display("FAIL mul_7x6: result=%h latency=%0d, required 0000002a latency 32", res, lat);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mul_busy_fall: busy=%b, required 0", bus.busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.valid !== 1'b0 || bus.result !== 32'd42) begin
         errors++;
         $display("FAIL valid_pulse: valid=%b result=%h, required 0 and 0000002a",
                  bus.valid, bus.result);
      end

      issue(c_sel_mulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'h0000_0000 || lat !== 32) begin
         errors++;
         $display("FAIL mulh_m1xm1: result=%h latency=%0d, required 00000000 latency 32", res, lat);
      end

      issue(c_sel_mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFE || lat !== 32) begin
         errors++;
         $display("FAIL mulhu_max: result=%h latency=%0d, required fffffffe latency 32", res, lat);
      end

      issue(c_sel_mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFF || lat !== 32) begin
         errors++;
         $display("FAIL mulhsu_m1xmax: result=%h latency=%0d, required ffffffff latency 32", res, lat);
      end

      // -2^31 * 3 = -0x1_8000_0000 -> 0xFFFFFFFE_80000000
      issue(c_sel_mulh, 32'h8000_0000, 32'd3);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFE || lat !== 32) begin
         errors++;
         $display("FAIL mulh_minx3: result=%h latency=%0d, required fffffffe latency 32", res, lat);
      end
   endtask

   task automatic test_div();
      logic [31:0] res;
      int          lat;
      issue(c_sel_div, 32'hFFFF_FFF9, 32'd2);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFD || lat !== 32) begin
         errors++;
         $display("FAIL div_m7_2: result=%h latency=%0d, required fffffffd latency 32", res, lat);
      end

      issue(c_sel_rem, 32'hFFFF_FFF9, 32'd2);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFF || lat !== 32) begin
         errors++;
         $display("FAIL rem_m7_2: result=%h latency=%0d, required ffffffff latency 32", res, lat);
      end

      issue(c_sel_divu, 32'hFFFF_FFF9, 32'd2);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'h7FFF_FFFC || lat !== 32) begin
         errors++;
         $display("FAIL divu_big_2: result=%h latency=%0d, required 7ffffffc latency 32", res, lat);
      end

      issue(c_sel_remu, 32'd100, 32'd7);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'd2 || lat !== 32) begin
         errors++;
         $display("FAIL remu_100_7: result=%h latency=%0d, required 00000002 latency 32", res, lat);
      end
   endtask

   task automatic test_boundary();
      logic [31:0] res;
      int          lat;
      issue(c_sel_div, 32'd5, 32'd0);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFF || lat !== 32) begin
         errors++;
         $display("FAIL div_5_by0: result=%h latency=%0d, required ffffffff latency 32", res, lat);
      end

      issue(c_sel_div, 32'hFFFF_FFFB, 32'd0);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFF || lat !== 32) begin
         errors++;
         $display("FAIL div_m5_by0: result=%h latency=%0d, required ffffffff latency 32", res, lat);
      end

      issue(c_sel_remu, 32'd5, 32'd0);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'd5 || lat !== 32) begin
         errors++;
         $display("FAIL remu_5_by0: result=%h latency=%0d, required 00000005 latency 32", res, lat);
      end

      issue(c_sel_rem, 32'hFFFF_FFFB, 32'd0);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'hFFFF_FFFB || lat !== 32) begin
         errors++;
         $display("FAIL rem_m5_by0: result=%h latency=%0d, required fffffffb latency 32", res, lat);
      end

      issue(c_sel_div, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'h8000_0000 || lat !== 32) begin
         errors++;
         $display("FAIL div_overflow: result=%h latency=%0d, required 80000000 latency 32", res, lat);
      end

      issue(c_sel_rem, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'd0 || lat !== 32) begin
         errors++;
         $display("FAIL rem_overflow: result=%h latency=%0d, required 00000000 latency 32", res, lat);
      end
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int          lat;
      int          seen;
      issue(c_sel_divu, 32'd100, 32'd7);
      wait_valid(res, lat);
      checks++;
      if (res !== 32'd14 || lat !== 32) begin
         errors++;
         $display("FAIL divu_100_7: result=%h latency=%0d, required 0000000e latency 32", res, lat);
      end

      // Flush lands on edge 10 of the operation.
      issue(c_sel_divu, 32'h0000_FFFF, 32'd3);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_mid: busy=%b valid=%b, required 0/0", bus.busy, bus.valid);
      end
      count_valid(40, seen);
      checks++;
      if (seen !== 0 || bus.result !== 32'd14) begin
         errors++;
         $display("FAIL flush_mid_after: %0d valid pulses result=%h, required 0 and 0000000e",
                  seen, bus.result);
      end

      // Flush lands on the completing edge 32 and must win.
      issue(c_sel_mul, 32'd7, 32'd6);
      repeat (31) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      checks++;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'd14) begin
         errors++;
         $display("FAIL flush_at_finish: valid=%b busy=%b result=%h, required 0/0/0000000e",
                  bus.valid, bus.busy, bus.result);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      int          lat;
      @(negedge clk);
      bus.select = c_sel_mul;
      bus.data1  = 32'd7;
      bus.data2  = 32'd6;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      // START stays high; the second op's operands are presented now and
      // must not disturb the running multiply.
      bus.select = c_sel_divu;
      bus.data1  = 32'd100;
      bus.data2  = 32'd7;
      wait_valid(res, lat);
      checks++;
      if (res !== 32'd42 || lat !== 32) begin
         errors++;
         $display("FAIL b2b_first: result=%h latency=%0d, required 0000002a latency 32", res, lat);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.valid !== 1'b0 || bus.result !== 32'd42) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b valid=%b result=%h, required 1/0/0000002a",
                  bus.busy, bus.valid, bus.result);
      end
      wait_valid(res, lat);
      checks++;
      if (res !== 32'd14 || lat !== 32) begin
         errors++;
         $display("FAIL b2b_second: result=%h latency=%0d, required 0000000e latency 32", res, lat);
      end
   endtask

   task automatic test_async_reset();
      int seen;
      issue(c_sel_mul, 32'h0001_2345, 32'h0000_0678);
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.result !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: busy=%b valid=%b result=%h, required 0/0/00000000",
                  bus.busy, bus.valid, bus.result);
      end
      @(negedge clk);
      rst = 1'b0;
      count_valid(40, seen);
      checks++;
      if (seen !== 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_after: %0d valid pulses busy=%b, required 0 and 0",
                  seen, bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_ignored();
      test_mul();
      test_div();
      test_boundary();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle RV32M execution unit in the EX stage, taking the same operand/SELECT interface as the single-cycle ALU. It consumes a START request from the EX-stage controller and runs a 32-iteration shift-add multiply or restoring divide. It returns a registered RESULT with a one-cycle VALID pulse. The EX-stage controller stalls the pipeline on BUSY.

## Interface
- No parameters; width fixed at 32 bits, iteration count fixed at 32.
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high; clears all state
- START  input  1  request; sampled only in IDLE
- FLUSH  input  1  synchronous abort of an in-flight operation
- SELECT  input  5  operation, `MUL/`MULH/`MULHSU/`MULHU/`DIV/`DIVU/`REM/`REMU from utils/encordings.v
- DATA1  input  32  rs1 operand (dividend / multiplicand)
- DATA2  input  32  rs2 operand (divisor / multiplier)
- RESULT  output  32  registered result; holds last completed value
- BUSY  output  1  high while an operation is in flight
- VALID  output  1  one-cycle pulse; RESULT is valid in that cycle

## Operation
- States:
  - IDLE: the accept state.
  - CALC: the 32-iteration state, with a 5-bit iteration counter.
- Accept rule: in IDLE, START=1, FLUSH=0 and SELECT one of the 8 M-ops → latch SELECT and the operand magnitudes, record the result sign, clear the accumulator, counter=31, go to CALC.
  - START with a non-M SELECT is ignored: stay IDLE, no VALID.
- Sign handling:
  - Operand magnitudes: DATA1 is signed for MULH, MULHSU, DIV, REM; DATA2 is signed for MULH, DIV, REM. A signed operand with bit31=1 is negated to its magnitude (0x80000000 stays 0x80000000, read as unsigned 2^31).
  - Result sign for MUL*: XOR of the operand signs.
  - Result sign for DIV: XOR of the operand signs. For REM: the dividend sign.
  - MUL takes the low 32 bits of the product, so it is sign-independent; treating it as unsigned is acceptable.
- Multiply (CALC): 64-bit accumulator, radix-2 shift-add, one multiplier bit per cycle.
- Divide (CALC): unsigned restoring division with a 33-bit partial remainder; one quotient bit per cycle, MSB first.
- Finish (the CALC cycle where counter==0, after its iteration):
  - Negate the 64-bit product, or the quotient/remainder, if the result sign is negative.
  - Select the output: MUL low[31:0], MULH/MULHSU/MULHU high[63:32], DIV/DIVU quotient, REM/REMU remainder.
  - Register RESULT, VALID=1, return to IDLE.
- Divide by zero (DATA2==0), overridden at finish:
  - DIV and DIVU → 0xFFFFFFFF.
  - REM and REMU → DATA1, the original value.
- Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF), overridden at finish:
  - DIV → 0x80000000.
  - REM → 0x00000000.
- FLUSH:
  - In CALC: go to IDLE next edge, VALID stays 0, RESULT unchanged.
  - In IDLE: blocks acceptance of START that cycle.
- Operand inputs may change freely after acceptance; only the latched copies are used.

## Timing
- Reset values: state IDLE, RESULT=0, BUSY=0, VALID=0, counter=0, accumulator=0.
- The accept edge is edge 0.
- BUSY: registered, rises at edge 0, falls at edge 32.
- Iterations happen at edges 1..32.
- At edge 32, VALID rises together with the RESULT update, and the state returns to IDLE.
- VALID falls at edge 33 unless a new operation completes there, which is impossible.
- Latency: 32 cycles, START edge to VALID edge; fixed for all ops, including divide-by-zero and overflow.
- Back-to-back:
  - START held high during the VALID cycle is accepted at edge 33.
  - Throughput is one op per 33 cycles.
- START while BUSY=1 is ignored; no queuing.
- FLUSH and a completion in the same edge (counter==0): FLUSH wins, no VALID, RESULT unchanged.
- RESET asserted mid-operation: all outputs clear immediately, asynchronously; no VALID after release.

## Test plan
- MUL 7×6 and MULH 0xFFFFFFFF×0xFFFFFFFF (−1×−1):
  - MUL → RESULT=42 with VALID exactly 32 cycles after START.
  - MULH → 0x00000000.
  - The same operands under MULHU → 0xFFFFFFFE.
- MULHSU, DATA1=0xFFFFFFFF, DATA2=0xFFFFFFFF → 0xFFFFFFFF.
- Signed division, DATA1=−7, DATA2=2:
  - DIV → 0xFFFFFFFD (−3).
  - REM → 0xFFFFFFFF (−1).
  - DIVU with the same operands → 0x7FFFFFFC.
- Boundary cases:
  - DIV x/0 with x=5 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000/−1 → 0.
- FLUSH behaviour:
  - FLUSH at cycle 10 of a DIVU → BUSY drops at the next edge, no VALID, RESULT keeps its previous value.
  - START held continuously → second op accepted in the VALID cycle of the first.
- Reset and ignored requests:
  - RESET pulsed mid-MUL → outputs 0 immediately, no VALID afterwards.
  - START with SELECT=`ADD → no BUSY, no VALID.
